operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  ID/EX pipeline register between the 32x64 register bank read ports and the execute stage.
//  Resolves each source operand from three places: the EX result, the WB result or the register-bank read data.
//  Stalls decode on a load-use hazard.
//  Single-entry valid/ready register with a flush and a hazard-cycle counter.
// PARAMETERS
//  DATA_WIDTH   64   operand/result width
//  ADDR_WIDTH   6    register address width (matches register bank ports)
//  OPC_WIDTH    11   opcode field carried alongside operands
//  ZERO_REG     31   register index that reads as zero (XZR), never forwarded
//  CNT_WIDTH    16   width of stall counter
// PORTS
//  clock          in   1           rising-edge clock
//  reset_n        in   1           asynchronous, active-low reset
//  in_valid       in   1           decode presents an instruction
//  in_ready       out  1           stage accepts instruction this cycle
//  in_opcode      in   OPC_WIDTH   opcode to carry
//  in_src_1       in   ADDR_WIDTH  source 1 addr (also drives bank input_address_1)
//  in_src_2       in   ADDR_WIDTH  source 2 addr (also drives bank input_address_2)
//  in_use_1       in   1           source 1 is read by this instruction
//  in_use_2       in   1           source 2 is read by this instruction
//  in_dest        in   ADDR_WIDTH  destination register
//  in_write       in   1           instruction writes in_dest
//  rf_data_1      in   DATA_WIDTH  bank output_data_1 (combinational)
//  rf_data_2      in   DATA_WIDTH  bank output_data_2 (combinational)
//  ex_write       in   1           EX stage will write ex_dest
//  ex_dest        in   ADDR_WIDTH  EX destination
//  ex_is_load     in   1           EX instruction is a load (ex_data not yet valid)
//  ex_data        in   DATA_WIDTH  EX ALU result
//  wb_write       in   1           WB writes bank this cycle (bank write)
//  wb_dest        in   ADDR_WIDTH  WB destination (bank input_address_3)
//  wb_data        in   DATA_WIDTH  WB data (bank input_data)
//  flush          in   1           synchronous squash (branch taken)
//  out_valid      out  1           registered instruction valid to EX
//  out_ready      in   1           EX accepts
//  out_opcode     out  OPC_WIDTH   registered opcode
//  out_operand_1  out  DATA_WIDTH  registered resolved operand 1
//  out_operand_2  out  DATA_WIDTH  registered resolved operand 2
//  out_dest       out  ADDR_WIDTH  registered destination
//  out_write      out  1           registered write enable
//  stall_count    out  CNT_WIDTH   saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (reset_n=0, async): out_valid=0, all out_* data=0, stall_count=0. No other state.
//  - Operand select, per source n, first match wins:
//    a. src==ZERO_REG -> 0
//    b. ex_write && !ex_is_load && ex_dest==src -> ex_data
//    c. wb_write && wb_dest==src -> wb_data (the bank write lands only at this same edge)
//    d. otherwise rf_data_n
//  - hazard = in_valid && ex_write && ex_is_load && ex_dest!=ZERO_REG &&
//    ((in_use_1 && ex_dest==in_src_1) || (in_use_2 && ex_dest==in_src_2)).
//  - in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational; no dependency on in_valid.
//  - capture = in_valid && in_ready. Capture loads out_* with the resolved operands at the edge.
//    Latency is 1 cycle, in to out.
//  - out_valid next state:
//    flush -> 0 (flush has priority);
//    else capture -> 1;
//    else out_ready -> 0;
//    else hold.
//  - Payload behaviour: out_* hold while out_valid && !out_ready, with no change.
//    Payload may be left stale when out_valid=0.
//  - stall_count increments on each cycle where hazard=1, and saturates at all-ones.
//  - Simultaneous out_ready and capture: the new instruction replaces the old in the same edge. There is no bubble.
//  - Reset mid-operation: the in-flight instruction is dropped. Upstream re-issues it after reset.
// TESTING
//  1 Reset: reset_n=0 mid-transfer -> out_valid=0 and stall_count=0 immediately, without waiting for a clock edge.
//  2 No hazard: src_1=3, rf_data_1=0x11, out_ready=1.
//    -> next cycle out_valid=1 and out_operand_1=0x11.
//    Then src_1=31 -> out_operand_1=0, even with ex_dest=31 and ex_data=0xFF.
//  3 Forwarding priority: src_1=5 with ex_write, ex_dest=5, ex_data=0xAA, wb_write, wb_dest=5, wb_data=0xBB -> out_operand_1=0xAA.
//    Drop ex_write -> 0xBB.
//  4 Load-use: ex_is_load=1, ex_dest=7, in_src_2=7, in_use_2=1, held 2 cycles.
//    -> in_ready=0 for those cycles and stall_count=2.
//    With in_use_2=0 -> no stall.
//  5 Backpressure: out_ready=0 for 3 cycles with in_valid=1.
//    -> out_* stable, in_ready=0.
//    Release -> next instruction captured the same edge.
//  6 Flush together with in_valid=1 and out_valid=1.
//    -> out_valid=0 next cycle, nothing captured.
//    Stall counter saturation: force 0xFFFF, then one more hazard cycle -> value stays 0xFFFF.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// ID/EX pipeline register: resolves source operands (zero reg, EX forward, WB forward, bank read),
// detects load-use hazards and holds one instruction under valid/ready handshaking.
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int OPC_WIDTH  = 11,
    parameter int ZERO_REG   = 31,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPC_WIDTH-1:0]  in_opcode,
    input  logic [ADDR_WIDTH-1:0] in_src_1,
    input  logic [ADDR_WIDTH-1:0] in_src_2,
    input  logic                  in_use_1,
    input  logic                  in_use_2,
    input  logic [ADDR_WIDTH-1:0] in_dest,
    input  logic                  in_write,
    input  logic [DATA_WIDTH-1:0] rf_data_1,
    input  logic [DATA_WIDTH-1:0] rf_data_2,
    input  logic                  ex_write,
    input  logic [ADDR_WIDTH-1:0] ex_dest,
    input  logic                  ex_is_load,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  wb_write,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPC_WIDTH-1:0]  out_opcode,
    output logic [DATA_WIDTH-1:0] out_operand_1,
    output logic [DATA_WIDTH-1:0] out_operand_2,
    output logic [ADDR_WIDTH-1:0] out_dest,
    output logic                  out_write,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  ex_fwd_ok;
    logic                  hit_1;
    logic                  hit_2;
    logic                  hazard;
    logic                  capture;

    // A load in EX has no data yet, so it never forwards; WB forwarding covers the
    // bank write that only lands at the same edge as this capture.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [ADDR_WIDTH-1:0] src,
        input logic [DATA_WIDTH-1:0] rf_val,
        input logic                  ex_ok,
        input logic [ADDR_WIDTH-1:0] ex_d,
        input logic [DATA_WIDTH-1:0] ex_val,
        input logic                  wb_w,
        input logic [ADDR_WIDTH-1:0] wb_d,
        input logic [DATA_WIDTH-1:0] wb_val
    );
        logic [DATA_WIDTH-1:0] result;
        if (src == ZERO_ADDR) begin
            result = '0;
        end else if (ex_ok && (ex_d == src)) begin
            result = ex_val;
        end else if (wb_w && (wb_d == src)) begin
            result = wb_val;
        end else begin
            result = rf_val;
        end
        return result;
    endfunction

    assign ex_fwd_ok = ex_write && !ex_is_load;

    always_comb begin
        operand_1 = resolve(in_src_1, rf_data_1, ex_fwd_ok, ex_dest, ex_data,
                            wb_write, wb_dest, wb_data);
        operand_2 = resolve(in_src_2, rf_data_2, ex_fwd_ok, ex_dest, ex_data,
                            wb_write, wb_dest, wb_data);
    end

    assign hit_1   = in_use_1 && (ex_dest == in_src_1);
    assign hit_2   = in_use_2 && (ex_dest == in_src_2);
    assign hazard  = in_valid && ex_write && ex_is_load && (ex_dest != ZERO_ADDR) &&
                     (hit_1 || hit_2);
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_opcode    <= '0;
            out_operand_1 <= '0;
            out_operand_2 <= '0;
            out_dest      <= '0;
            out_write     <= 1'b0;
        end else if (capture) begin
            out_opcode    <= in_opcode;
            out_operand_1 <= operand_1;
            out_operand_2 <= operand_2;
            out_dest      <= in_dest;
            out_write     <= in_write;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != {CNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_operand_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid, in_use_1, in_use_2, in_write;
    logic [10:0] in_opcode;
    logic [5:0]  in_src_1, in_src_2, in_dest;
    logic [63:0] rf_data_1, rf_data_2;
    logic        ex_write, ex_is_load, wb_write, flush, out_ready;
    logic [5:0]  ex_dest, wb_dest;
    logic [63:0] ex_data, wb_data;

    logic        in_ready, out_valid, out_write;
    logic [10:0] out_opcode;
    logic [63:0] out_operand_1, out_operand_2;
    logic [5:0]  out_dest;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid, s_out_write;
    logic [10:0] s_out_opcode;
    logic [63:0] s_out_operand_1, s_out_operand_2;
    logic [5:0]  s_out_dest;
    logic [3:0]  s_stall_count;

    always #5 clock = ~clock;

    operand_fetch_stage dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_src_1(in_src_1), .in_src_2(in_src_2),
        .in_use_1(in_use_1), .in_use_2(in_use_2), .in_dest(in_dest), .in_write(in_write),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .ex_write(ex_write), .ex_dest(ex_dest),
        .ex_is_load(ex_is_load), .ex_data(ex_data), .wb_write(wb_write), .wb_dest(wb_dest),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
        .out_dest(out_dest), .out_write(out_write), .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    operand_fetch_stage #(.CNT_WIDTH(4)) dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_opcode(in_opcode), .in_src_1(in_src_1), .in_src_2(in_src_2),
        .in_use_1(in_use_1), .in_use_2(in_use_2), .in_dest(in_dest), .in_write(in_write),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .ex_write(ex_write), .ex_dest(ex_dest),
        .ex_is_load(ex_is_load), .ex_data(ex_data), .wb_write(wb_write), .wb_dest(wb_dest),
        .wb_data(wb_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_opcode(s_out_opcode), .out_operand_1(s_out_operand_1),
        .out_operand_2(s_out_operand_2), .out_dest(s_out_dest), .out_write(s_out_write),
        .stall_count(s_stall_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [10:0] m_opc;
    logic [63:0] m_op1, m_op2;
    logic [5:0]  m_dest;
    logic        m_write;
    int          m_cnt, m_cnt_s;

    typedef struct {
        logic [5:0]  src1;
        logic        use1;
        logic [63:0] rf1;
        logic        exw;
        logic [5:0]  exd;
        logic        exl;
        logic [63:0] exdata;
        logic        wbw;
        logic [5:0]  wbd;
        logic [63:0] wbdata;
        logic [63:0] exp_op1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_operand(input logic [5:0] src, input logic [63:0] rf);
        if (src == 6'd31) return 64'd0;
        if (ex_write && !ex_is_load && ex_dest == src) return ex_data;
        if (wb_write && wb_dest == src) return wb_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_opc = '0; m_op1 = '0; m_op2 = '0; m_dest = '0; m_write = 1'b0;
        m_cnt = 0; m_cnt_s = 0;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        logic haz, rdy, cap;
        logic [63:0] n_op1, n_op2;
        #4;
        haz = in_valid && ex_write && ex_is_load && ex_dest != 6'd31 &&
              ((in_use_1 && ex_dest == in_src_1) || (in_use_2 && ex_dest == in_src_2));
        rdy = (!m_valid || out_ready) && !haz && !flush;
        cap = in_valid && rdy;
        n_op1 = model_operand(in_src_1, rf_data_1);
        n_op2 = model_operand(in_src_2, rf_data_2);
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        chk("in_ready_sat", {63'd0, s_in_ready}, {63'd0, rdy});
        if (cap) begin
            m_opc = in_opcode; m_op1 = n_op1; m_op2 = n_op2; m_dest = in_dest; m_write = in_write;
        end
        if (flush) m_valid = 1'b0;
        else if (cap) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        if (haz && m_cnt < 65535) m_cnt++;
        if (haz && m_cnt_s < 15) m_cnt_s++;
        @(posedge clock);
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("out_opcode", {53'd0, out_opcode}, {53'd0, m_opc});
            chk("out_operand_1", out_operand_1, m_op1);
            chk("out_operand_2", out_operand_2, m_op2);
            chk("out_dest", {58'd0, out_dest}, {58'd0, m_dest});
            chk("out_write", {63'd0, out_write}, {63'd0, m_write});
        end
        chk("stall_count", {48'd0, stall_count}, 64'(m_cnt));
        chk("stall_count_sat", {60'd0, s_stall_count}, 64'(m_cnt_s));
    endtask

    task automatic set_idle();
        in_valid = 0; in_use_1 = 0; in_use_2 = 0; in_write = 0; in_opcode = '0;
        in_src_1 = '0; in_src_2 = '0; in_dest = '0; rf_data_1 = '0; rf_data_2 = '0;
        ex_write = 0; ex_is_load = 0; ex_dest = '0; ex_data = '0;
        wb_write = 0; wb_dest = '0; wb_data = '0; flush = 0; out_ready = 1;
    endtask

    function automatic logic [5:0] pick_addr();
        int t;
        t = $urandom_range(0, 4);
        return (t == 4) ? 6'd31 : 6'(t);
    endfunction

    initial begin
        vecs[0] = '{6'd3,  1'b1, 64'h11, 1'b0, 6'd0,  1'b0, 64'h0,  1'b0, 6'd0,  64'h0,  64'h11};
        vecs[1] = '{6'd31, 1'b1, 64'h55, 1'b1, 6'd31, 1'b0, 64'hFF, 1'b0, 6'd0,  64'h0,  64'h0};
        vecs[2] = '{6'd5,  1'b1, 64'h33, 1'b1, 6'd5,  1'b0, 64'hAA, 1'b1, 6'd5,  64'hBB, 64'hAA};
        vecs[3] = '{6'd5,  1'b1, 64'h33, 1'b0, 6'd5,  1'b0, 64'hAA, 1'b1, 6'd5,  64'hBB, 64'hBB};
        vecs[4] = '{6'd5,  1'b0, 64'h77, 1'b1, 6'd5,  1'b1, 64'hAA, 1'b0, 6'd0,  64'h0,  64'h77};
        vecs[5] = '{6'd31, 1'b1, 64'h66, 1'b0, 6'd0,  1'b0, 64'h0,  1'b1, 6'd31, 64'hCC, 64'h0};
        vecs[6] = '{6'd2,  1'b1, 64'h44, 1'b1, 6'd3,  1'b0, 64'hAA, 1'b1, 6'd4,  64'hBB, 64'h44};

        set_idle();
        model_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_stall_count", {48'd0, stall_count}, 64'd0);
        chk("reset_operand_1", out_operand_1, 64'd0);
        reset_n = 1'b1;

        // Operand selection table
        for (int i = 0; i < 7; i++) begin
            set_idle();
            in_valid = 1; out_ready = 1; in_opcode = 11'(i + 1);
            in_src_1 = vecs[i].src1; in_use_1 = vecs[i].use1; rf_data_1 = vecs[i].rf1;
            ex_write = vecs[i].exw; ex_dest = vecs[i].exd; ex_is_load = vecs[i].exl;
            ex_data = vecs[i].exdata; wb_write = vecs[i].wbw; wb_dest = vecs[i].wbd;
            wb_data = vecs[i].wbdata; in_src_2 = 6'd1; rf_data_2 = 64'h1234;
            tick();
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_operand_1", i), out_operand_1, vecs[i].exp_op1);
        end

        // Backpressure: A held, B waits, then B replaces A on the release edge
        set_idle();
        in_valid = 1; in_opcode = 11'h0A1; in_src_1 = 6'd2; rf_data_1 = 64'h5A;
        tick();
        in_opcode = 11'h0B2; rf_data_1 = 64'h6B; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            chk("bp_hold_opcode", {53'd0, out_opcode}, 64'h0A1);
            chk("bp_hold_operand_1", out_operand_1, 64'h5A);
        end
        out_ready = 1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("bp_new_opcode", {53'd0, out_opcode}, 64'h0B2);
        chk("bp_new_valid", {63'd0, out_valid}, 64'd1);

        // Flush with in_valid and out_valid both high
        in_opcode = 11'h0C3; out_ready = 0; flush = 1;
        tick();
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        flush = 0; out_ready = 1;

        // Build up state, then assert reset mid-cycle
        in_valid = 1; in_opcode = 11'h0D4;
        tick();
        ex_write = 1; ex_is_load = 1; ex_dest = 6'd2; in_src_1 = 6'd2; in_use_1 = 1;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
        chk("async_reset_count", {48'd0, stall_count}, 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Load-use on source 2
        set_idle();
        in_valid = 1; ex_write = 1; ex_is_load = 1; ex_dest = 6'd7;
        in_src_2 = 6'd7; in_use_2 = 1; in_src_1 = 6'd1; in_use_1 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lu_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        chk("lu_stall_count", {48'd0, stall_count}, 64'd2);
        in_use_2 = 0;
        #1;
        chk("lu_unused_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("lu_stall_hold", {48'd0, stall_count}, 64'd2);

        // Load into the zero register never stalls
        ex_dest = 6'd31; in_src_2 = 6'd31; in_use_2 = 1;
        tick();
        chk("zero_reg_no_stall", {48'd0, stall_count}, 64'd2);

        // Saturation on the narrow counter
        ex_dest = 6'd7; in_src_2 = 6'd7;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count", {60'd0, s_stall_count}, 64'hF);
        chk("wide_count", {48'd0, stall_count}, 64'd22);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_opcode  = 11'($urandom);
            in_src_1   = pick_addr();
            in_src_2   = pick_addr();
            in_use_1   = 1'($urandom);
            in_use_2   = 1'($urandom);
            in_dest    = pick_addr();
            in_write   = 1'($urandom);
            rf_data_1  = {$urandom, $urandom};
            rf_data_2  = {$urandom, $urandom};
            ex_write   = 1'($urandom);
            ex_dest    = pick_addr();
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_data    = {$urandom, $urandom};
            wb_write   = 1'($urandom);
            wb_dest    = pick_addr();
            wb_data    = {$urandom, $urandom};
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
